// File: rtl/usbfs_ep_in_tx.sv
`default_nettype none
// ============================================================================
// Module      : usbfs_ep_in_tx
// Description : USB full-speed IN endpoint transmit controller. Collects
//               application bytes into a local packet buffer, answers host IN
//               tokens with DATA0/DATA1, NAK or STALL, copies the packet into
//               the transmitter's buffer, and keeps the data for retry until
//               the host ACKs it.
// Ports       : i_clk_48MHz      - sole clock
//               i_rst            - synchronous active-high reset
//               i_strobe_12MHz   - bit-rate strobe (one cycle wide)
//               i_inToken        - IN token for this endpoint (pulse)
//               i_ack / i_timeout- host handshake outcome (pulses)
//               i_setup          - SETUP transaction received (pulse)
//               i_stall          - endpoint halted (level)
//               i_valid/o_ready/i_data - application byte stream
//               o_txValid/i_txReady/o_txPid - packet request to transmitter
//               o_txWrEn/o_txWrIdx/o_txWrByte - transmitter buffer write port
//               i_txEopDone      - transmitter finished EOP
//               o_busy           - controller not idle
// Revision    : 1.0 - initial release
// ============================================================================
module usbfs_ep_in_tx #(
    parameter int  MAX_PKT = 8,
    localparam int IDX_W   = $clog2(MAX_PKT),
    localparam int CNT_W   = $clog2(MAX_PKT + 1)
) (
    input  logic             i_clk_48MHz,
    input  logic             i_rst,
    input  logic             i_strobe_12MHz,
    input  logic             i_inToken,
    input  logic             i_ack,
    input  logic             i_timeout,
    input  logic             i_setup,
    input  logic             i_stall,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [7:0]       i_data,
    output logic             o_txValid,
    input  logic             i_txReady,
    output logic [3:0]       o_txPid,
    output logic             o_txWrEn,
    output logic [IDX_W-1:0] o_txWrIdx,
    output logic [7:0]       o_txWrByte,
    input  logic             i_txEopDone,
    output logic             o_busy
);

    localparam logic [3:0]       c_PID_DATA0 = 4'b0011;
    localparam logic [3:0]       c_PID_DATA1 = 4'b1011;
    localparam logic [3:0]       c_PID_NAK   = 4'b1010;
    localparam logic [3:0]       c_PID_STALL = 4'b1110;
    localparam logic [CNT_W-1:0] c_MAX_CNT   = CNT_W'(MAX_PKT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COPY     = 3'd1,
        SEND     = 3'd2,
        WAIT_EOP = 3'd3,
        WAIT_HS  = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_copyIdx;
    logic             r_toggle;
    logic             r_isData;
    logic [7:0]       r_buf [MAX_PKT];

    state_t           w_stateNext;
    logic [CNT_W-1:0] w_cntNext;
    logic [CNT_W-1:0] w_copyIdxNext;
    logic             w_toggleNext;
    logic             w_isDataNext;
    logic [3:0]       w_pidNext;
    logic             w_txValidNext;
    logic             w_wrEnNext;
    logic [IDX_W-1:0] w_wrIdxNext;
    logic [7:0]       w_wrByteNext;
    logic             w_busyNext;
    logic             w_push;

    // Bytes are only taken while idle, and never in a cycle that also starts
    // a transaction, so the count sampled for the pid choice is stable.
    assign o_ready = (r_state == IDLE) && (r_cnt < c_MAX_CNT) && !i_inToken && !i_setup;
    assign w_push  = i_valid && o_ready;

    always_ff @(posedge i_clk_48MHz) begin
        if (w_push) begin
            r_buf[r_cnt[IDX_W-1:0]] <= i_data;
        end
    end

    always_ff @(posedge i_clk_48MHz) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_copyIdx  <= '0;
            r_toggle   <= 1'b0;
            r_isData   <= 1'b0;
            o_txPid    <= c_PID_DATA0;
            o_txValid  <= 1'b0;
            o_txWrEn   <= 1'b0;
            o_txWrIdx  <= '0;
            o_txWrByte <= '0;
            o_busy     <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_copyIdx  <= w_copyIdxNext;
            r_toggle   <= w_toggleNext;
            r_isData   <= w_isDataNext;
            o_txPid    <= w_pidNext;
            o_txValid  <= w_txValidNext;
            o_txWrEn   <= w_wrEnNext;
            o_txWrIdx  <= w_wrIdxNext;
            o_txWrByte <= w_wrByteNext;
            o_busy     <= w_busyNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = w_push ? r_cnt + CNT_W'(1) : r_cnt;
        w_copyIdxNext = r_copyIdx;
        w_toggleNext  = r_toggle;
        w_isDataNext  = r_isData;
        w_pidNext     = o_txPid;
        w_txValidNext = o_txValid;
        w_wrEnNext    = 1'b0;
        w_wrIdxNext   = o_txWrIdx;
        w_wrByteNext  = o_txWrByte;

        if (i_setup) begin
            // SETUP resets the data toggle to DATA1 and discards any pending
            // packet, whatever else happens in this cycle.
            w_stateNext   = IDLE;
            w_cntNext     = '0;
            w_toggleNext  = 1'b1;
            w_txValidNext = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_inToken) begin
                        if (i_stall) begin
                            w_pidNext     = c_PID_STALL;
                            w_isDataNext  = 1'b0;
                            w_stateNext   = SEND;
                            w_txValidNext = 1'b1;
                        end else if (r_cnt == '0) begin
                            w_pidNext     = c_PID_NAK;
                            w_isDataNext  = 1'b0;
                            w_stateNext   = SEND;
                            w_txValidNext = 1'b1;
                        end else begin
                            w_pidNext     = r_toggle ? c_PID_DATA1 : c_PID_DATA0;
                            w_isDataNext  = 1'b1;
                            w_stateNext   = COPY;
                            w_copyIdxNext = '0;
                        end
                    end
                end
                COPY: begin
                    if (r_copyIdx < r_cnt) begin
                        w_wrEnNext    = 1'b1;
                        w_wrIdxNext   = r_copyIdx[IDX_W-1:0];
                        w_wrByteNext  = r_buf[r_copyIdx[IDX_W-1:0]];
                        w_copyIdxNext = r_copyIdx + CNT_W'(1);
                    end else begin
                        w_stateNext   = SEND;
                        w_txValidNext = 1'b1;
                    end
                end
                SEND: begin
                    if (i_strobe_12MHz && i_txReady && o_txValid) begin
                        w_stateNext   = WAIT_EOP;
                        w_txValidNext = 1'b0;
                    end
                end
                WAIT_EOP: begin
                    if (i_txEopDone) begin
                        w_stateNext = r_isData ? WAIT_HS : IDLE;
                    end
                end
                WAIT_HS: begin
                    if (i_ack) begin
                        w_cntNext    = '0;
                        w_toggleNext = ~r_toggle;
                        w_stateNext  = IDLE;
                    end else if (i_timeout) begin
                        // Buffer, count and toggle stay put for the retry.
                        w_stateNext  = IDLE;
                    end
                end
                default: begin
                    w_stateNext   = IDLE;
                    w_txValidNext = 1'b0;
                end
            endcase
        end

        w_busyNext = (w_stateNext != IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_usbfs_ep_in_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_usbfs_ep_in_tx
// Description : Self-checking bench for usbfs_ep_in_tx. A queue-based model
//               of the endpoint (pending bytes + data toggle) predicts PIDs,
//               copied bytes and buffer acceptance under directed and random
//               transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usbfs_ep_in_tx;

    localparam int MAX_PKT = 8;
    localparam int IDX_W   = $clog2(MAX_PKT);

    logic             clk = 1'b0;
    logic             rst, strobe, inToken, ack, timeout, setup, stall;
    logic             valid, ready, txValid, txReady, txWrEn, txEopDone, busy;
    logic [7:0]       data, txWrByte;
    logic [3:0]       txPid;
    logic [IDX_W-1:0] txWrIdx;

    int nCmp = 0;
    int nErr = 0;

    logic [7:0] mq[$];
    logic       mTog;

    always #10 clk = ~clk;

    usbfs_ep_in_tx #(.MAX_PKT(MAX_PKT)) dut (
        .i_clk_48MHz   (clk),
        .i_rst         (rst),
        .i_strobe_12MHz(strobe),
        .i_inToken     (inToken),
        .i_ack         (ack),
        .i_timeout     (timeout),
        .i_setup       (setup),
        .i_stall       (stall),
        .i_valid       (valid),
        .o_ready       (ready),
        .i_data        (data),
        .o_txValid     (txValid),
        .i_txReady     (txReady),
        .o_txPid       (txPid),
        .o_txWrEn      (txWrEn),
        .o_txWrIdx     (txWrIdx),
        .o_txWrByte    (txWrByte),
        .i_txEopDone   (txEopDone),
        .o_busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clearIn();
        strobe = 0; inToken = 0; ack = 0; timeout = 0; setup = 0;
        valid = 0; txReady = 0; txEopDone = 0;
    endtask

    task automatic doReset();
        clearIn();
        stall = 0;
        rst   = 1;
        tick(); tick();
        rst   = 0;
        mq.delete();
        mTog  = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        valid = 1; data = b;
        #1;
        chk("ready", ready, mq.size() < MAX_PKT);
        tick();
        valid = 0;
        if (mq.size() < MAX_PKT) mq.push_back(b);
    endtask

    // outcome: 0 ack, 1 timeout, 2 ack+timeout together, 3 setup
    task automatic doIn(input bit stl, input int outcome, input bit collide);
        logic [3:0] expPid;
        bit         isData;
        int         n, guard;
        bit         went;
        isData = !stl && (mq.size() != 0);
        expPid = stl ? 4'b1110 : (mq.size() == 0) ? 4'b1010 : (mTog ? 4'b1011 : 4'b0011);

        inToken = 1; stall = stl;
        if (collide) begin
            valid = 1; data = 8'($urandom);
            #1;
            chk("readyOnToken", ready, 0);
        end
        tick();
        inToken = 0; valid = 0; stall = $urandom_range(0, 1);
        chk("busyStart", busy, 1);

        n = 0; guard = 0;
        while (!txValid && guard < MAX_PKT + 4) begin
            if (txWrEn) begin
                chk("wrIdx", txWrIdx, n);
                chk("wrByte", txWrByte, (n < mq.size()) ? mq[n] : 8'h00);
                n++;
            end
            tick();
            guard++;
        end
        chk("txValidUp", txValid, 1);
        chk("nWrites", n, isData ? mq.size() : 0);
        chk("pid", txPid, expPid);

        went = 0; guard = 0;
        while (!went && guard < 200) begin
            strobe  = ($urandom_range(0, 2) == 0) || guard > 100;
            txReady = $urandom_range(0, 1) || guard > 100;
            inToken = ($urandom_range(0, 4) == 0);
            ack     = ($urandom_range(0, 5) == 0);
            timeout = ($urandom_range(0, 5) == 0);
            valid   = ($urandom_range(0, 3) == 0);
            #1;
            chk("readyBusy", ready, 0);
            chk("wrEnSend", txWrEn, 0);
            went = strobe && txReady;
            tick();
            clearIn();
            guard++;
        end
        chk("transfer", went, 1);
        chk("txValidDown", txValid, 0);
        chk("busyEop", busy, 1);

        repeat ($urandom_range(0, 3)) begin
            ack = ($urandom_range(0, 2) == 0);
            timeout = ($urandom_range(0, 2) == 0);
            inToken = ($urandom_range(0, 2) == 0);
            tick();
            clearIn();
        end
        txEopDone = 1;
        tick();
        txEopDone = 0;

        if (!isData) begin
            chk("busyIdleHs", busy, 0);
        end else begin
            chk("busyWaitHs", busy, 1);
            case (outcome)
                0: ack = 1;
                1: timeout = 1;
                2: begin ack = 1; timeout = 1; end
                default: setup = 1;
            endcase
            tick();
            clearIn();
            case (outcome)
                0, 2: begin mq.delete(); mTog = ~mTog; end
                1: ;
                default: begin mq.delete(); mTog = 1'b1; end
            endcase
            chk("busyDone", busy, 0);
            chk("txValidDone", txValid, 0);
            chk("wrEnDone", txWrEn, 0);
        end
        chk("pidHeld", txPid, expPid);
        #1;
        chk("readyIdle", ready, mq.size() < MAX_PKT);
    endtask

    initial begin
        stall = 0; data = 0; rst = 1;
        clearIn();
        doReset();

        // reset state
        chk("rstValid", txValid, 0);
        chk("rstWrEn", txWrEn, 0);
        chk("rstWrIdx", txWrIdx, 0);
        chk("rstWrByte", txWrByte, 0);
        chk("rstPid", txPid, 4'b0011);
        chk("rstBusy", busy, 0);
        #1;
        chk("rstReady", ready, 1);

        // empty IN -> NAK
        doIn(0, 0, 0);

        // 3-byte packet, then next packet uses DATA1
        push(8'h11); push(8'h22); push(8'h33);
        doIn(0, 0, 0);
        push(8'h44);
        doIn(0, 0, 0);

        // retry: timeout keeps bytes and PID
        doReset();
        push(8'hA5); push(8'h5A);
        doIn(0, 1, 0);
        doIn(0, 0, 0);

        // full buffer
        for (int i = 0; i < MAX_PKT + 2; i++) push(8'(i * 7 + 3));
        chk("fullCount", mq.size(), MAX_PKT);
        doIn(0, 0, 0);

        // stall with 4 bytes keeps buffer; setup during WAIT_HS
        for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
        doIn(1, 0, 0);
        chk("stallKeeps", mq.size(), 4);
        doIn(0, 3, 0);
        push(8'h77);
        doIn(0, 0, 0);

        // collisions: token with byte, ack with timeout
        push(8'h01);
        doIn(0, 2, 1);

        // reset in the middle of a copy abandons the packet
        push(8'h10); push(8'h20); push(8'h30);
        inToken = 1; tick(); inToken = 0;
        tick();
        rst = 1; tick(); rst = 0;
        mq.delete(); mTog = 1'b0;
        chk("midRstBusy", busy, 0);
        chk("midRstWrEn", txWrEn, 0);
        chk("midRstPid", txPid, 4'b0011);
        doIn(0, 0, 0);

        // randomized transactions
        for (int it = 0; it < 40; it++) begin
            int np;
            np = $urandom_range(0, MAX_PKT + 1);
            for (int k = 0; k < np; k++) push(8'($urandom));
            doIn($urandom_range(0, 5) == 0, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
`default_nettype wire
